// File: rtl/door_controller.sv
// door_controller: elevator door FSM with button conditioning, stroke/dwell timing and door-open level P
module door_controller #(
  parameter int DEB_CYCLES = 16,
  parameter int MOVE_TIME  = 2,
  parameter int OPEN_TIME  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       B_open,
  input  logic       B_close,
  input  logic       obst,
  output logic       P,
  output logic       motor_open,
  output logic       motor_close,
  output logic [1:0] estado
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [3:0] MT = 4'(MOVE_TIME);
  localparam logic [3:0] OT = 4'(OPEN_TIME);
  typedef enum logic [1:0] {CLOSED = 2'b00, OPENING = 2'b01, OPEN = 2'b10, CLOSING = 2'b11} state_t;
  state_t state, state_n;
  logic [3:0] timer, timer_n, rev;
  logic [1:0] raw, s1, s2, deb, evt;
  logic [CW-1:0] cnt [2];
  logic expiry, wake;
  assign raw = {B_close, B_open};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1  <= '1;
      s2  <= '1;
      deb <= '1;
      cnt <= '{default: '0};
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == DEB_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  // event fires in the cycle the debounced level is about to fall, so the FSM reacts on the same edge
  assign evt = deb & ~s2 & {cnt[1] == DEB_LAST, cnt[0] == DEB_LAST};
  assign expiry = tick && timer == 4'd1;
  assign wake = evt[0] | obst;
  assign rev = MT - timer;
  always_comb begin
    state_n = state;
    timer_n = (tick && timer != 4'd0) ? timer - 4'd1 : timer;
    case (state)
      CLOSED:
        if (evt[0]) begin
          state_n = OPENING;
          timer_n = MT;
        end
      OPENING:
        if (expiry) begin
          state_n = OPEN;
          timer_n = OT;
        end
      OPEN:
        if (wake) timer_n = OT;
        else if (evt[1] || expiry) begin
          state_n = CLOSING;
          timer_n = MT;
        end
      CLOSING:
        if (wake) begin
          state_n = OPENING;
          timer_n = (rev == 4'd0) ? 4'd1 : rev;
        end else if (expiry) begin
          state_n = CLOSED;
          timer_n = 4'd0;
        end
      default: state_n = CLOSED;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= CLOSED;
      timer       <= 4'd0;
      P           <= 1'b0;
      motor_open  <= 1'b0;
      motor_close <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      P           <= state_n == OPEN;
      motor_open  <= state_n == OPENING;
      motor_close <= state_n == CLOSING;
    end
  assign estado = state;
endmodule

// File: tb/tb_door_controller.sv
// tb_door_controller: table-driven vectors plus hand sequences for door_controller
module tb_door_controller;
  logic clk = 0, reset = 1, tick = 0, B_open = 1, B_close = 1, obst = 0;
  logic P, motor_open, motor_close;
  logic [1:0] estado;
  int total = 0, bad = 0;
  localparam logic [2:0] CL = 3'b000, OPG = 3'b010, OP = 3'b100, CLG = 3'b001;
  door_controller #(.DEB_CYCLES(4), .MOVE_TIME(2), .OPEN_TIME(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .B_open(B_open), .B_close(B_close), .obst(obst),
    .P(P), .motor_open(motor_open), .motor_close(motor_close), .estado(estado)
  );
  always #5 clk = ~clk;
  typedef struct {
    string      nm;
    int         n;
    logic       tk, bo, bc, ob;
    logic [1:0] es;
    logic [2:0] pmm;
  } vec_t;
  vec_t v[$];
  function automatic void add(string nm, int n, logic tk, logic bo, logic bc, logic ob, logic [1:0] es, logic [2:0] pmm);
    vec_t x;
    x.nm = nm; x.n = n; x.tk = tk; x.bo = bo; x.bc = bc; x.ob = ob; x.es = es; x.pmm = pmm;
    v.push_back(x);
  endfunction
  task automatic check(string nm, logic [1:0] es, logic [2:0] pmm);
    total++;
    if ({estado, P, motor_open, motor_close} !== {es, pmm}) begin
      bad++;
      $display("FAIL %s: got estado=%b P/mo/mc=%b%b%b, want estado=%b P/mo/mc=%b",
               nm, estado, P, motor_open, motor_close, es, pmm);
    end
  endtask
  task automatic cyc(logic tk);
    tick = tk;
    @(posedge clk);
    #1;
    tick = 0;
  endtask
  initial begin
    // door open/close through debounce, dwell, and close
    add("s1_sync",    5, 0, 0, 1, 0, 2'd0, CL);
    add("s1_evt",     1, 0, 0, 1, 0, 2'd1, OPG);
    add("s1_hold",    4, 0, 0, 1, 0, 2'd1, OPG);
    add("s1_tick1",   1, 1, 1, 1, 0, 2'd1, OPG);
    add("s1_open",    1, 1, 1, 1, 0, 2'd2, OP);
    add("s2_dwell",   2, 1, 1, 1, 0, 2'd2, OP);
    add("s2_close",   1, 1, 1, 1, 0, 2'd3, CLG);
    add("s2_notick",  3, 0, 1, 1, 0, 2'd3, CLG);
    add("s2_tick",    1, 1, 1, 1, 0, 2'd3, CLG);
    add("s2_closed",  1, 1, 1, 1, 0, 2'd0, CL);
    add("cl_ignored", 8, 0, 1, 0, 0, 2'd0, CL);
    add("cl_release", 8, 0, 1, 1, 0, 2'd0, CL);
    for (int i = 0; i < 5; i++) begin
      add("bounce_lo", 2, 0, 0, 1, 0, 2'd0, CL);
      add("bounce_hi", 2, 0, 1, 1, 0, 2'd0, CL);
    end
    add("bounce_rel", 10, 0, 1, 1, 0, 2'd0, CL);
    add("s4_press",   6, 0, 0, 1, 0, 2'd1, OPG);
    add("s4_stroke",  2, 1, 1, 1, 0, 2'd2, OP);
    add("s4_dwell",   2, 1, 1, 1, 0, 2'd2, OP);
    add("s4_expire",  1, 1, 1, 1, 0, 2'd3, CLG);
    add("s4_tick",    1, 1, 1, 1, 0, 2'd3, CLG);
    add("s4_obst",    1, 0, 1, 1, 1, 2'd1, OPG);
    add("s4_reopen",  1, 1, 1, 1, 0, 2'd2, OP);
    add("ob_dwell",   2, 1, 1, 1, 0, 2'd2, OP);
    add("ob_reload",  1, 1, 1, 1, 1, 2'd2, OP);
    add("ob_dwell2",  2, 1, 1, 1, 0, 2'd2, OP);
    add("ob_expire",  1, 1, 1, 1, 0, 2'd3, CLG);
    add("rev_min",    1, 1, 1, 1, 1, 2'd1, OPG);
    add("rev_one",    1, 1, 1, 1, 0, 2'd2, OP);
    add("fin_dwell",  2, 1, 1, 1, 0, 2'd2, OP);
    add("fin_close",  1, 1, 1, 1, 0, 2'd3, CLG);
    add("fin_closed", 2, 1, 1, 1, 0, 2'd0, CL);
    add("ob_closed",  3, 1, 1, 1, 1, 2'd0, CL);
    add("ob_clear",   2, 0, 1, 1, 0, 2'd0, CL);
    #2 reset = 0;
    #20;
    check("reset_state", 2'd0, CL);
    @(posedge clk);
    #1 reset = 1;
    foreach (v[k]) begin
      B_open = v[k].bo;
      B_close = v[k].bc;
      obst = v[k].ob;
      for (int c = 0; c < v[k].n; c++) cyc(v[k].tk);
      check(v[k].nm, v[k].es, v[k].pmm);
    end
    obst = 0;
    // simultaneous open and close events while OPEN, coinciding with an expiry tick
    B_open = 0;
    repeat (6) cyc(0);
    check("s5_opening", 2'd1, OPG);
    B_open = 1;
    cyc(1);
    cyc(1);
    check("s5_open", 2'd2, OP);
    repeat (8) cyc(0);
    check("s5_idle", 2'd2, OP);
    B_open = 0;
    B_close = 0;
    cyc(0);
    cyc(1);
    cyc(1);
    cyc(0);
    cyc(0);
    check("s5_pre", 2'd2, OP);
    cyc(1);
    check("s5_both", 2'd2, OP);
    B_open = 1;
    B_close = 1;
    repeat (8) cyc(0);
    cyc(1);
    cyc(1);
    check("s5_reload", 2'd2, OP);
    B_close = 0;
    repeat (5) cyc(0);
    check("s5_cpre", 2'd2, OP);
    cyc(0);
    check("s5_close", 2'd3, CLG);
    B_close = 1;
    cyc(1);
    cyc(1);
    check("s5_closed", 2'd0, CL);
    // asynchronous reset mid-stroke
    repeat (8) cyc(0);
    B_open = 0;
    repeat (6) cyc(0);
    check("s6_opening", 2'd1, OPG);
    cyc(1);
    check("s6_midstroke", 2'd1, OPG);
    @(negedge clk);
    reset = 0;
    #1;
    check("s6_async", 2'd0, CL);
    B_open = 1;
    @(posedge clk);
    #3 reset = 1;
    repeat (10) cyc(1);
    check("s6_stay", 2'd0, CL);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
